// File: rtl/fv_binds_mem_pkg.sv
// Shared types and dword mapping helpers for the FV memory snapshot bind layer.
package fv_binds_mem_pkg;

    typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;

    localparam int DW_BITS    = 32;
    localparam int MAX_WORD_W = 256;

    function automatic int dw_per_word(input int word_w);
        return word_w / DW_BITS;
    endfunction

    // m is the byte offset of the dword inside the (zero-extended) memory word.
    function automatic logic [31:0] dw_map(input logic [MAX_WORD_W-1:0] word,
                                           input int                    m,
                                           input logic                  swap);
        logic [31:0] dw;
        dw = 32'(word >> (m * 8));
        return swap ? {dw[7:0], dw[15:8], dw[23:16], dw[31:24]} : dw;
    endfunction

endpackage

// File: rtl/fv_binds_mem_flatten.sv
// Combinational mapper: DUT memory of any supported word width -> flat dword view.
module fv_binds_mem_flatten
    import fv_binds_mem_pkg::*;
#(
    parameter int MEM_SIZE       = 1024,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BYTE_SWAP      = 0
) (
    input  logic [MEM_SIZE/(MEM_DATA_WIDTH/8)-1:0][MEM_DATA_WIDTH-1:0] mem_in,
    output logic [MEM_SIZE/4-1:0][31:0]                                dws
);

    localparam int NUM_DW = MEM_SIZE / 4;
    localparam int DPW    = dw_per_word(MEM_DATA_WIDTH);

    for (genvar n = 0; n < NUM_DW; n++) begin : g_dw
        assign dws[n] = dw_map(MAX_WORD_W'(mem_in[n / DPW]), (n % DPW) * 4, BYTE_SWAP != 0);
    end

endmodule

// File: rtl/fv_binds_mem_snapshot.sv
// Captures a dword window of a bound DUT memory into a shadow and streams it
// over valid/ready, keeping an XOR checksum and a saturating snapshot count.
module fv_binds_mem_snapshot
    import fv_binds_mem_pkg::*;
#(
    parameter int MEM_SIZE       = 1024,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_DEPTH      = MEM_SIZE / (MEM_DATA_WIDTH / 8),
    parameter int WIN_START      = 0,
    parameter int WIN_LEN        = MEM_SIZE / 4,
    parameter int BYTE_SWAP      = 0,
    parameter int IDX_W          = (MEM_SIZE / 4 > 1) ? $clog2(MEM_SIZE / 4) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [MEM_DEPTH-1:0][MEM_DATA_WIDTH-1:0]  mem_in,
    input  logic                                      snap_req,
    output logic                                      busy,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [IDX_W-1:0]                          out_idx,
    output logic [31:0]                               out_data,
    output logic                                      out_last,
    output logic                                      done,
    output logic [31:0]                               checksum,
    output logic [15:0]                               snap_count
);

    localparam int NUM_DW = MEM_SIZE / 4;
    localparam int PTR_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    if (MEM_DATA_WIDTH != 32 && MEM_DATA_WIDTH != 64 &&
        MEM_DATA_WIDTH != 128 && MEM_DATA_WIDTH != 256) begin : g_bad_width
        $fatal(1, "MEM_DATA_WIDTH must be 32, 64, 128 or 256");
    end
    if (MEM_SIZE < 4 || (MEM_SIZE % (MEM_DATA_WIDTH / 8)) != 0 ||
        MEM_DEPTH != MEM_SIZE / (MEM_DATA_WIDTH / 8)) begin : g_bad_size
        $fatal(1, "MEM_SIZE must be a whole number of memory words");
    end
    if (WIN_LEN < 1 || WIN_START < 0 || WIN_START + WIN_LEN > NUM_DW) begin : g_bad_window
        $fatal(1, "capture window out of range");
    end
    if (BYTE_SWAP != 0 && BYTE_SWAP != 1) begin : g_bad_swap
        $fatal(1, "BYTE_SWAP must be 0 or 1");
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NUM_DW-1:0][31:0] dws;
    logic [31:0]             shadow [WIN_LEN];
    state_t                  state;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        ptr_nxt;
    logic                    hs;

    fv_binds_mem_flatten #(
        .MEM_SIZE       (MEM_SIZE),
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
        .BYTE_SWAP      (BYTE_SWAP)
    ) u_flatten (
        .mem_in (mem_in),
        .dws    (dws)
    );

    assign hs      = out_valid & out_ready;
    assign ptr_nxt = ptr + 1'b1;

    // Shadow holds data only; it is rewritten on every capture and needs no reset.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            for (int i = 0; i < WIN_LEN; i++) begin
                shadow[i] <= dws[WIN_START + i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            out_idx    <= IDX_W'(WIN_START);
            out_data   <= '0;
            checksum   <= '0;
            snap_count <= '0;
            ptr        <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (snap_req) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    // First beat comes straight from the live view; it equals shadow[0].
                    state     <= STREAM;
                    ptr       <= '0;
                    checksum  <= '0;
                    out_valid <= 1'b1;
                    out_idx   <= IDX_W'(WIN_START);
                    out_data  <= dws[WIN_START];
                    out_last  <= (WIN_LEN == 1);
                end
                STREAM: begin
                    if (hs) begin
                        checksum <= checksum ^ out_data;
                        if (out_last) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            done       <= 1'b1;
                            snap_count <= sat_inc(snap_count);
                        end else begin
                            ptr      <= ptr_nxt;
                            out_idx  <= out_idx + 1'b1;
                            out_data <= shadow[ptr_nxt];
                            out_last <= (ptr_nxt == PTR_W'(WIN_LEN - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fv_binds_mem_snapshot.md
Name: fv_binds_mem_snapshot

Overview:
- Parametrised successor to the combinational FV memory-mapping binds.
- Flattens a DUT memory of any power-of-two word width into a dword view, with optional byte swap.
- On request, captures a window of that view into a shadow register, then streams it dword by dword over a valid/ready handshake.
- Keeps a running XOR checksum and a snapshot counter. Sits in the FV bind layer, between bound DUT memories and checkers or trace sinks.

Parameters:
- MEM_SIZE, 1024, memory size in bytes; multiple of MEM_DATA_WIDTH/8.
- MEM_DATA_WIDTH, 64, DUT memory word width in bits; one of 32, 64, 128, 256.
- MEM_DEPTH, MEM_SIZE/(MEM_DATA_WIDTH/8), DUT memory word count (derived).
- WIN_START, 0, first dword index of the captured window.
- WIN_LEN, MEM_SIZE/4, window length in dwords; at least 1, and WIN_START+WIN_LEN at most MEM_SIZE/4.
- BYTE_SWAP, 0, 1 reverses byte order inside each dword (big-endian DUT).
- IDX_W, $clog2(MEM_SIZE/4) (minimum 1), dword index width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mem_in  in  [MEM_DEPTH-1:0][MEM_DATA_WIDTH-1:0]  bound DUT memory, packed; word 0 at the low index.
- snap_req  in  1  capture request; sampled only in IDLE.
- busy  out  1  high in CAPTURE and STREAM.
- out_valid  out  1  streamed dword valid.
- out_ready  in  1  sink ready.
- out_idx  out  IDX_W  absolute dword index of out_data.
- out_data  out  32  captured dword.
- out_last  out  1  marks the final beat of the window.
- done  out  1  one-cycle pulse after the last handshake.
- checksum  out  32  XOR of all dwords handshaken in the current or most recent snapshot.
- snap_count  out  16  completed snapshots, saturating at 16'hFFFF.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on rst, with clock clk; both are fixed.
- Reset values: state=IDLE, busy=0, out_valid=0, out_last=0, done=0, out_idx=WIN_START, out_data=0, checksum=0, snap_count=0. Shadow contents are don't-care.
- Dword mapping, n in 0..MEM_SIZE/4-1:
  - k = n/(MEM_DATA_WIDTH/32), m = (n % (MEM_DATA_WIDTH/32))*4.
  - dw = {byte m+3, m+2, m+1, m} of mem_in[k].
  - BYTE_SWAP=1 gives {m, m+1, m+2, m+3}.
- FSM, state IDLE:
  - snap_req=1 -> CAPTURE.
  - done drives 0 except in the cycle after the last handshake.
- FSM, state CAPTURE: lasts exactly one cycle.
  - Latch dwords WIN_START..WIN_START+WIN_LEN-1 into the shadow.
  - checksum<=0, pointer<=0.
  - Go to STREAM.
- FSM, state STREAM:
  - out_valid=1. out_data=shadow[pointer], out_idx=WIN_START+pointer, out_last=(pointer==WIN_LEN-1).
  - Handshake = out_valid & out_ready: checksum^=out_data, pointer++.
  - Handshake with out_last -> IDLE, done=1 the next cycle, snap_count++ (saturating).
- Latency: snap_req high in cycle t. Memory is sampled at the end of t+1 (CAPTURE). First out_valid is at t+2.
- Minimum snapshot: WIN_LEN+2 cycles with out_ready tied high.
- Handshake stability: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable. out_valid never drops without a handshake.
- Boundary conditions:
  - snap_req while busy is ignored, not queued.
  - snap_req in the done cycle (state IDLE) is accepted.
  - WIN_LEN=1: the first beat carries out_last=1.
  - mem_in changes after CAPTURE do not affect the streamed data.
  - rst mid-STREAM returns to reset values next cycle; no done pulse, and snap_count is cleared.
  - checksum holds its final value in IDLE until the next CAPTURE.
- Elaboration checks: illegal parameter combinations (width not in set, window out of range, WIN_LEN=0) fail via $fatal.

Decomposition:
- Package fv_binds_mem_pkg:
  - state enum typedef {IDLE, CAPTURE, STREAM}.
  - function dw_map(word, m, swap) returning the 32-bit dword.
  - localparam helpers for DW_PER_WORD.
- Sub-module fv_binds_mem_flatten: combinational generalised mapper, mem_in -> [MEM_SIZE/4-1:0][31:0] with BYTE_SWAP. Instantiated once.
- Capture, FSM and stream logic live in the top.

Test Plan:
- Defaults, mem_in[0]=64'h8877665544332211, out_ready=1, pulse snap_req -> beat 0: idx 0, data 32'h44332211. Beat 1: idx 1, data 32'h88776655. out_last on idx 255, done 2 cycles after snap_req plus 256 beats, snap_count=1.
- BYTE_SWAP=1, same word -> beat 0 data 32'h11223344, beat 1 data 32'h55667788.
- MEM_DATA_WIDTH=128, WIN_START=5, WIN_LEN=3, mem_in[1]=128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> idx 5,6,7 with data BBBBBBBB, CCCCCCCC, DDDDDDDD. out_last on idx 7, checksum = XOR of the three beats.
- out_ready toggled 1,0,0,1, plus mem_in rewritten after CAPTURE -> data and idx held stable during stalls, shadow (pre-write) values streamed, each index exactly once.
- snap_req pulsed mid-STREAM and again in the done cycle -> first ignored; second starts CAPTURE next cycle, checksum clears, snap_count reaches 2.
- rst asserted at beat 10 -> next cycle out_valid=0, busy=0, snap_count=0, no done pulse; a fresh snap_req restarts at idx WIN_START.
